// File: rtl/depth_test_pkg.sv
// Shared types for the depth test unit: compare functions, control states
// and the fragment record carried through the pipeline.
package depth_test_pkg;

   localparam int FRAG_ADDR_W  = 15;
   localparam int FRAG_DEPTH_W = 12;
   localparam int FRAG_COLOR_W = 4;

   typedef enum logic [1:0] {
      CMP_LESS   = 2'd0,
      CMP_LEQUAL = 2'd1,
      CMP_ALWAYS = 2'd2,
      CMP_NEVER  = 2'd3
   } cmp_func_e;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      CLEAR = 2'd2
   } state_e;

   typedef struct packed {
      logic [FRAG_ADDR_W-1:0]  addr;
      logic [FRAG_DEPTH_W-1:0] depth;
      logic [FRAG_COLOR_W-1:0] color;
      cmp_func_e               cmp_func;
      logic                    wr_mask;
   } fragment_t;

endpackage

// File: rtl/depth_compare.sv
// Combinational depth test: unsigned, full-width compare of a fragment depth
// against the stored (or forwarded) depth under the selected function.
module depth_compare
   import depth_test_pkg::*;
#(
   parameter int DB_DATA_WIDTH = 12
) (
   input  logic [DB_DATA_WIDTH-1:0] depth,
   input  logic [DB_DATA_WIDTH-1:0] stored,
   input  cmp_func_e                cmp_func,
   output logic                     pass
);

   // Evaluate the selected compare function
   always_comb begin
      pass = 1'b0;
      case (cmp_func)
         CMP_LESS:   pass = (depth < stored);
         CMP_LEQUAL: pass = (depth <= stored);
         CMP_ALWAYS: pass = 1'b1;
         default:    pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/depth_test_unit.sv
// Pipelined Z-buffer test-and-write engine with write forwarding and a
// buffer clear sequencer. Stage 0 issues the depth read, stage 1 compares
// against the RAM data (or a forwarded in-flight write), stage 2 drives the
// registered write strobes.
module depth_test_unit
   import depth_test_pkg::*;
#(
   parameter int                       BUFFER_DEPTH   = 19200,
   parameter int                       ADDR_WIDTH     = 15,
   parameter int                       DB_DATA_WIDTH  = 12,
   parameter int                       FB_DATA_WIDTH  = 4,
   parameter logic [DB_DATA_WIDTH-1:0] DB_CLEAR_VALUE = '1,
   parameter logic [FB_DATA_WIDTH-1:0] FB_CLEAR_VALUE = '0,
   parameter bit                       CLEAR_ON_RESET = 1'b1,
   parameter int                       COUNT_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [ADDR_WIDTH-1:0]    i_addr,
   input  logic [DB_DATA_WIDTH-1:0] i_depth,
   input  logic [FB_DATA_WIDTH-1:0] i_color,
   input  logic [1:0]               i_cmp_func,
   input  logic                     i_depth_wr_mask,
   input  logic                     i_clear,
   output logic                     o_clear_done,
   output logic [ADDR_WIDTH-1:0]    db_rd_addr,
   input  logic [DB_DATA_WIDTH-1:0] db_rd_data,
   output logic                     db_wr_en,
   output logic [ADDR_WIDTH-1:0]    db_wr_addr,
   output logic [DB_DATA_WIDTH-1:0] db_wr_data,
   output logic                     fb_wr_en,
   output logic [ADDR_WIDTH-1:0]    fb_wr_addr,
   output logic [FB_DATA_WIDTH-1:0] fb_wr_data,
   output logic [COUNT_WIDTH-1:0]   o_pass_count
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(BUFFER_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BUFFER_DEPTH - 1);

   state_e                   state, state_next;
   logic                     clear_entry;
   logic [ADDR_WIDTH-1:0]    clear_addr;
   logic                     accept;
   logic                     in_range;

   logic                     vld_p1;
   logic [ADDR_WIDTH-1:0]    addr_p1;
   logic [DB_DATA_WIDTH-1:0] depth_p1;
   logic [FB_DATA_WIDTH-1:0] color_p1;
   cmp_func_e                func_p1;
   logic                     mask_p1;
   logic                     in_range_p1;

   logic                     w1_hit, w2_hit;
   logic [DB_DATA_WIDTH-1:0] stored_p1;
   logic                     cmp_pass_p1;
   logic                     pass_p1;

   logic                     vld_p2;
   logic                     w2_en_p3;
   logic [ADDR_WIDTH-1:0]    w2_addr_p3;
   logic [DB_DATA_WIDTH-1:0] w2_data_p3;

   assign accept     = i_valid && o_ready;
   assign in_range   = ({1'b0, i_addr} < DEPTH_EXT);
   assign db_rd_addr = i_addr;

   // Control state register
   always_ff @(posedge clk) begin
      if (rst) state <= CLEAR_ON_RESET ? CLEAR : RUN;
      else     state <= state_next;
   end

   // Next-state and handshake decode; i_clear wins over a same-cycle fragment
   always_comb begin
      state_next  = state;
      o_ready     = 1'b0;
      clear_entry = 1'b0;
      case (state)
         RUN: begin
            o_ready = !i_clear && !rst;
            if (i_clear) state_next = DRAIN;
         end
         DRAIN: begin
            if (!vld_p1 && !vld_p2) begin
               state_next  = CLEAR;
               clear_entry = 1'b1;
            end
         end
         CLEAR: begin
            if (clear_addr == LAST_ADDR) state_next = RUN;
         end
         default: state_next = RUN;
      endcase
   end

   // Clear sweep address, one pixel per cycle, wrapping back to 0 at the end
   always_ff @(posedge clk) begin
      if (rst || clear_entry)  clear_addr <= '0;
      else if (state == CLEAR) clear_addr <= (clear_addr == LAST_ADDR) ? '0 : clear_addr + ADDR_WIDTH'(1);
   end

   // ---- stage 0 -> stage 1: fragment accepted, RAM read in flight ----
   // Compare-stage occupancy
   always_ff @(posedge clk) begin
      if (rst) vld_p1 <= 1'b0;
      else     vld_p1 <= accept;
   end

   // Compare-stage payload (qualified by vld_p1, so no reset needed)
   always_ff @(posedge clk) begin
      addr_p1     <= i_addr;
      depth_p1    <= i_depth;
      color_p1    <= i_color;
      func_p1     <= cmp_func_e'(i_cmp_func);
      mask_p1     <= i_depth_wr_mask;
      in_range_p1 <= in_range;
   end

   // ---- stage 1: compare against RAM data or forwarded in-flight depth ----
   // The RAM is read-first, so the writes one and two cycles older are not
   // yet visible in db_rd_data; the newer one (W1) takes priority.
   assign w1_hit    = db_wr_en && (db_wr_addr == addr_p1);
   assign w2_hit    = w2_en_p3 && (w2_addr_p3 == addr_p1);
   assign stored_p1 = w1_hit ? db_wr_data : (w2_hit ? w2_data_p3 : db_rd_data);

   depth_compare #(
      .DB_DATA_WIDTH (DB_DATA_WIDTH)
   ) u_depth_compare (
      .depth    (depth_p1),
      .stored   (stored_p1),
      .cmp_func (func_p1),
      .pass     (cmp_pass_p1)
   );

   assign pass_p1 = vld_p1 && in_range_p1 && cmp_pass_p1;

   // ---- stage 1 -> stage 2: registered write strobes (pipeline or clear) ----
   // Write-stage outputs, the W2 history register and the sweep-done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p2       <= 1'b0;
         db_wr_en     <= 1'b0;
         fb_wr_en     <= 1'b0;
         db_wr_addr   <= '0;
         fb_wr_addr   <= '0;
         db_wr_data   <= '0;
         fb_wr_data   <= '0;
         o_clear_done <= 1'b0;
         w2_en_p3     <= 1'b0;
         w2_addr_p3   <= '0;
         w2_data_p3   <= '0;
      end else begin
         vld_p2       <= vld_p1;
         o_clear_done <= (state == CLEAR) && (clear_addr == LAST_ADDR);
         w2_en_p3     <= db_wr_en;
         w2_addr_p3   <= db_wr_addr;
         w2_data_p3   <= db_wr_data;
         if (state == CLEAR) begin
            db_wr_en   <= 1'b1;
            fb_wr_en   <= 1'b1;
            db_wr_addr <= clear_addr;
            fb_wr_addr <= clear_addr;
            db_wr_data <= DB_CLEAR_VALUE;
            fb_wr_data <= FB_CLEAR_VALUE;
         end else begin
            db_wr_en   <= pass_p1 && mask_p1;
            fb_wr_en   <= pass_p1;
            db_wr_addr <= addr_p1;
            fb_wr_addr <= addr_p1;
            db_wr_data <= depth_p1;
            fb_wr_data <= color_p1;
         end
      end
   end

   // Passed-fragment counter, zeroed when a clear sweep begins
   always_ff @(posedge clk) begin
      if (rst || clear_entry) o_pass_count <= '0;
      else if (pass_p1)       o_pass_count <= o_pass_count + COUNT_WIDTH'(1);
   end

endmodule

// File: tb/tb_depth_test_unit.sv
// Scoreboard bench for depth_test_unit: a depth RAM model feeds the DUT, the
// stimulus side predicts writes from a per-pixel depth array, and a monitor
// compares every write strobe the DUT presents.
module tb_depth_test_unit;
   import depth_test_pkg::*;

   localparam int BD = 19200;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid;
   logic        o_ready;
   logic [14:0] i_addr;
   logic [11:0] i_depth;
   logic [3:0]  i_color;
   logic [1:0]  i_cmp_func;
   logic        i_depth_wr_mask;
   logic        i_clear;
   logic        o_clear_done;
   logic [14:0] db_rd_addr;
   logic [11:0] db_rd_data;
   logic        db_wr_en;
   logic [14:0] db_wr_addr;
   logic [11:0] db_wr_data;
   logic        fb_wr_en;
   logic [14:0] fb_wr_addr;
   logic [3:0]  fb_wr_data;
   logic [31:0] o_pass_count;

   depth_test_unit dut (
      .clk             (clk),
      .rst             (rst),
      .i_valid         (i_valid),
      .o_ready         (o_ready),
      .i_addr          (i_addr),
      .i_depth         (i_depth),
      .i_color         (i_color),
      .i_cmp_func      (i_cmp_func),
      .i_depth_wr_mask (i_depth_wr_mask),
      .i_clear         (i_clear),
      .o_clear_done    (o_clear_done),
      .db_rd_addr      (db_rd_addr),
      .db_rd_data      (db_rd_data),
      .db_wr_en        (db_wr_en),
      .db_wr_addr      (db_wr_addr),
      .db_wr_data      (db_wr_data),
      .fb_wr_en        (fb_wr_en),
      .fb_wr_addr      (fb_wr_addr),
      .fb_wr_data      (fb_wr_data),
      .o_pass_count    (o_pass_count)
   );

   // Reference compare unit, cross-checked against the bench's own rule
   logic [11:0] ref_depth, ref_stored;
   cmp_func_e   ref_func;
   logic        ref_pass;
   depth_compare #(.DB_DATA_WIDTH(12)) u_ref_cmp (
      .depth    (ref_depth),
      .stored   (ref_stored),
      .cmp_func (ref_func),
      .pass     (ref_pass)
   );

   always #5 clk = ~clk;

   // External depth RAM: 1-cycle latency, read-first
   logic [11:0] ram_db [32768];
   initial for (int i = 0; i < 32768; i++) ram_db[i] = 12'($urandom);
   always @(posedge clk) begin
      db_rd_data <= ram_db[db_rd_addr];
      if (db_wr_en) ram_db[db_wr_addr] <= db_wr_data;
   end

   typedef struct {
      logic        db_en;
      logic [14:0] addr;
      logic [11:0] depth;
      logic [3:0]  color;
   } exp_t;

   exp_t        exp_q[$];
   logic [11:0] db_model [BD];
   int          model_count = 0;
   int          errors = 0;
   int          checks = 0;
   int          done_cnt = 0;
   int          clr_idx = 0;
   int          frag_writes = 0;
   bit          expect_clear = 1'b0;

   task automatic check(input bit ok, input string name, input string detail);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: %s", name, detail);
      end
   endtask

   function automatic bit model_pass(input int func, input int d, input int s);
      case (func)
         0:       return d < s;
         1:       return d <= s;
         2:       return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic fragment_t make_frag(input int a, input int d, input int c,
                                           input cmp_func_e fn, input bit m);
      fragment_t f;
      f.addr     = 15'(a);
      f.depth    = 12'(d);
      f.color    = 4'(c);
      f.cmp_func = fn;
      f.wr_mask  = m;
      return f;
   endfunction

   task automatic reset_model();
      for (int i = 0; i < BD; i++) db_model[i] = 12'hFFF;
      model_count = 0;
   endtask

   task automatic issue(input fragment_t f);
      bit p;
      @(negedge clk);
      i_valid         = 1'b1;
      i_addr          = f.addr;
      i_depth         = f.depth;
      i_color         = f.color;
      i_cmp_func      = f.cmp_func;
      i_depth_wr_mask = f.wr_mask;
      ref_depth       = f.depth;
      ref_func        = f.cmp_func;
      ref_stored      = (int'(f.addr) < BD) ? db_model[f.addr] : 12'h0;
      #1;
      check(o_ready === 1'b1, "accept", $sformatf("o_ready=%b required 1", o_ready));
      if (o_ready === 1'b1 && int'(f.addr) < BD) begin
         p = model_pass(int'(f.cmp_func), int'(f.depth), int'(db_model[f.addr]));
         check(ref_pass === p, "cmp_unit",
               $sformatf("pass=%b required %b (func=%0d d=%h s=%h)", ref_pass, p, f.cmp_func, f.depth, ref_stored));
         if (p) begin
            exp_q.push_back('{f.wr_mask, f.addr, f.depth, f.color});
            if (f.wr_mask) db_model[f.addr] = f.depth;
            model_count++;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         i_valid = 1'b0;
         i_clear = 1'b0;
      end
   endtask

   task automatic drain_check(input string tag);
      idle(5);
      check(exp_q.size() == 0, {tag, "_queue"}, $sformatf("pending=%0d required 0", exp_q.size()));
      check(o_pass_count == 32'(model_count), {tag, "_count"},
            $sformatf("count=%0d required %0d", o_pass_count, model_count));
   endtask

   task automatic wait_clear(input string tag);
      int cyc = 0;
      int ready_seen = 0;
      int start_done = done_cnt;
      while (done_cnt == start_done && cyc < BD + 200) begin
         @(negedge clk);
         #2;
         cyc++;
         if (done_cnt == start_done && o_ready) ready_seen++;
      end
      check(done_cnt == start_done + 1, {tag, "_done"}, $sformatf("done pulses=%0d required 1", done_cnt - start_done));
      check(ready_seen == 0, {tag, "_ready_low"}, $sformatf("ready high cycles=%0d required 0", ready_seen));
      check(cyc >= BD, {tag, "_length"}, $sformatf("cycles=%0d required >= %0d", cyc, BD));
      @(negedge clk);
      #2;
      check(o_clear_done == 1'b0, {tag, "_done_pulse"}, $sformatf("o_clear_done=%b required 0", o_clear_done));
      check(o_ready == 1'b1, {tag, "_ready_after"}, $sformatf("o_ready=%b required 1", o_ready));
      check(o_pass_count == 32'd0, {tag, "_count_zero"}, $sformatf("count=%0d required 0", o_pass_count));
      reset_model();
   endtask

   // Monitor: every write strobe is either a predicted fragment write or the next clear write
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && (db_wr_en || fb_wr_en)) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               frag_writes++;
               check(fb_wr_en && (db_wr_en == e.db_en) && (fb_wr_addr == e.addr) && (fb_wr_data == e.color)
                     && (!e.db_en || (db_wr_addr == e.addr && db_wr_data == e.depth)), "frag_write",
                     $sformatf("fb=%b db=%b addr=%h/%h d=%h c=%h required fb=1 db=%b addr=%h d=%h c=%h",
                               fb_wr_en, db_wr_en, fb_wr_addr, db_wr_addr, db_wr_data, fb_wr_data,
                               e.db_en, e.addr, e.depth, e.color));
            end else if (expect_clear) begin
               if (clr_idx == 0)
                  check(o_pass_count == 32'd0, "clear_start_count", $sformatf("count=%0d required 0", o_pass_count));
               check(db_wr_en && fb_wr_en && int'(db_wr_addr) == clr_idx && int'(fb_wr_addr) == clr_idx
                     && db_wr_data == 12'hFFF && fb_wr_data == 4'h0, "clear_write",
                     $sformatf("en=%b%b addr=%h/%h d=%h c=%h required addr=%h d=fff c=0",
                               db_wr_en, fb_wr_en, db_wr_addr, fb_wr_addr, db_wr_data, fb_wr_data, clr_idx));
               clr_idx++;
            end else begin
               check(1'b0 || (db_wr_en == 1'b0 && fb_wr_en == 1'b0), "unexpected_write",
                     $sformatf("db=%b fb=%b addr=%h required no write", db_wr_en, fb_wr_en, fb_wr_addr));
            end
         end
         if (!rst && o_clear_done) begin
            check(expect_clear && clr_idx == BD, "clear_sweep",
                  $sformatf("writes=%0d required %0d", clr_idx, BD));
            done_cnt++;
            clr_idx = 0;
            expect_clear = 1'b0;
         end
      end
   end

   // Stimulus
   initial begin
      int base_w;
      int base_c;
      rst = 1'b1;
      i_valid = 1'b0; i_addr = '0; i_depth = '0; i_color = '0;
      i_cmp_func = '0; i_depth_wr_mask = 1'b0; i_clear = 1'b0;
      ref_depth = '0; ref_stored = '0; ref_func = CMP_LESS;
      expect_clear = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check(o_ready == 1'b0, "rst_ready", $sformatf("o_ready=%b required 0", o_ready));
      check(!db_wr_en && !fb_wr_en, "rst_strobes", $sformatf("db=%b fb=%b required 0", db_wr_en, fb_wr_en));
      check(o_pass_count == 32'd0, "rst_count", $sformatf("count=%0d required 0", o_pass_count));
      check(o_clear_done == 1'b0, "rst_done", $sformatf("done=%b required 0", o_clear_done));
      rst = 1'b0;
      wait_clear("reset_clear");

      // Back-to-back LESS on one pixel, then a W2-forwarded failure
      issue(make_frag(5, 'h100, 1, CMP_LESS, 1'b1));
      issue(make_frag(5, 'h080, 2, CMP_LESS, 1'b1));
      idle(1);
      issue(make_frag(5, 'h090, 3, CMP_LESS, 1'b1));
      drain_check("fwd_less");

      // LEQUAL twice on equal depth, then LESS fails
      issue(make_frag(7, 'h200, 4, CMP_LEQUAL, 1'b1));
      issue(make_frag(7, 'h200, 5, CMP_LEQUAL, 1'b1));
      issue(make_frag(7, 'h200, 6, CMP_LESS, 1'b1));
      drain_check("lequal");

      // Colour-only write leaves stored depth untouched
      issue(make_frag(9, 'h010, 7, CMP_LESS, 1'b0));
      issue(make_frag(9, 'h020, 8, CMP_LESS, 1'b1));
      drain_check("wr_mask");

      // Randomized mix on a small address window, with some out-of-range pixels
      for (int n = 0; n < 300; n++) begin
         int a;
         a = ($urandom_range(0, 15) == 0) ? int'($urandom_range(BD, 32767)) : int'($urandom_range(0, 11));
         issue(make_frag(a, int'($urandom_range(0, 4095)), int'($urandom_range(0, 15)),
                         cmp_func_e'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0)));
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end
      drain_check("random");

      // Clear request with a same-cycle fragment and fragments still in flight
      issue(make_frag(3, 'h050, 9, CMP_ALWAYS, 1'b1));
      issue(make_frag(4, 'h060, 10, CMP_ALWAYS, 1'b1));
      @(negedge clk);
      expect_clear = 1'b1;
      i_valid = 1'b1; i_addr = 15'd6; i_depth = 12'h010; i_cmp_func = 2'd2; i_clear = 1'b1;
      #1;
      check(o_ready == 1'b0, "clear_priority", $sformatf("o_ready=%b required 0", o_ready));
      @(negedge clk);
      i_valid = 1'b0; i_clear = 1'b0;
      wait_clear("req_clear");

      // NEVER: no writes at all
      base_w = frag_writes;
      base_c = model_count;
      for (int n = 0; n < 100; n++)
         issue(make_frag(int'($urandom_range(0, BD - 1)), int'($urandom_range(0, 4095)), 1, CMP_NEVER, 1'b1));
      drain_check("never");
      check(frag_writes == base_w && o_pass_count == 32'(base_c), "never_writes",
            $sformatf("writes=%0d count=%0d required 0 and %0d", frag_writes - base_w, o_pass_count, base_c));

      // ALWAYS: every fragment writes and counts
      base_w = frag_writes;
      for (int n = 0; n < 100; n++)
         issue(make_frag(int'($urandom_range(0, BD - 1)), int'($urandom_range(0, 4095)),
                         int'($urandom_range(0, 15)), CMP_ALWAYS, 1'b1));
      drain_check("always");
      check(frag_writes - base_w == 100 && o_pass_count == 32'd100, "always_writes",
            $sformatf("writes=%0d count=%0d required 100 and 100", frag_writes - base_w, o_pass_count));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time bound
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "time limit");
   end

endmodule

// File: doc/depth_test_unit.md
Name: depth_test_unit

Overview:
- Single-clock, pipelined Z-buffer test-and-write engine.
- Sits between the rasterizer fragment stream and externally instantiated depth and framebuffer RAMs.
- Accepts one fragment per cycle with valid/ready, supports a selectable compare function per fragment and forwards in-flight writes so back-to-back fragments on the same address see correct depth.
- Owns a buffer clear sequencer that sweeps both buffers after reset or on request.

Parameters:
- BUFFER_DEPTH, 19200, number of pixels, 160x120.
- ADDR_WIDTH, 15, buffer address width; must satisfy 2^ADDR_WIDTH >= BUFFER_DEPTH.
- DB_DATA_WIDTH, 12, depth word width.
- FB_DATA_WIDTH, 4, colour index width.
- DB_CLEAR_VALUE, all ones, depth value written on clear.
- FB_CLEAR_VALUE, 0, colour value written on clear.
- CLEAR_ON_RESET, 1, if 1 a clear sweep starts automatically after reset.
- COUNT_WIDTH, 32, width of the passed-fragment counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  fragment valid
- o_ready  out  1  fragment accepted when i_valid && o_ready
- i_addr  in  ADDR_WIDTH  pixel address
- i_depth  in  DB_DATA_WIDTH  fragment depth
- i_color  in  FB_DATA_WIDTH  fragment colour index
- i_cmp_func  in  2  0=LESS, 1=LEQUAL, 2=ALWAYS, 3=NEVER; sampled with the fragment
- i_depth_wr_mask  in  1  1 = update depth on pass; colour is always written on pass
- i_clear  in  1  request clear (pulse)
- o_clear_done  out  1  one-cycle pulse at end of sweep
- db_rd_addr  out  ADDR_WIDTH  depth RAM read address (combinational from i_addr)
- db_rd_data  in  DB_DATA_WIDTH  depth RAM data, 1-cycle latency, read-first
- db_wr_en / db_wr_addr / db_wr_data  out  1 / ADDR_WIDTH / DB_DATA_WIDTH  depth RAM write
- fb_wr_en / fb_wr_addr / fb_wr_data  out  1 / ADDR_WIDTH / FB_DATA_WIDTH  framebuffer write
- o_pass_count  out  COUNT_WIDTH  fragments passed since last clear start

Behaviour:
- Reset: all outputs 0; o_ready=0.
  - State goes to CLEAR if CLEAR_ON_RESET=1, else RUN.
  - Reset mid-sweep or mid-pipeline discards everything and restarts.
- States and transitions:
  - RUN: o_ready=1.
  - i_clear in RUN moves to DRAIN; o_ready drops the same cycle, so i_clear has priority over a same-cycle fragment, which is not accepted.
  - DRAIN: o_ready=0 until the compare and write stages are empty, then CLEAR.
  - CLEAR: writes address 0..BUFFER_DEPTH-1, one per cycle, with db_wr_en=fb_wr_en=1, DB_CLEAR_VALUE and FB_CLEAR_VALUE.
  - After the last address, o_clear_done pulses for one cycle and the state returns to RUN.
  - i_clear during DRAIN or CLEAR is ignored.
  - o_pass_count is zeroed on entry to CLEAR.
- Pipeline timing for a fragment F accepted in cycle c:
  - db_rd_addr=F.addr in cycle c.
  - Compare stage in c+1 uses db_rd_data.
  - Write strobes are registered and high in c+2; the RAM commits at the end of c+2.
  - Sustained throughput is 1 fragment per cycle.
- Forwarding:
  - The compare stage replaces db_rd_data with the depth of the youngest older fragment that wrote depth to the same address.
  - Source W1 is the fragment in the write stage, one older. Source W2 is the last write-stage contents, two older.
  - W1 has priority over W2.
  - Only fragments that passed and had i_depth_wr_mask=1 are forwarded.
- Compare: pass = (LESS: depth < stored) | (LEQUAL: depth <= stored) | ALWAYS | never for NEVER.
  - Comparison is unsigned, full width.
- On pass:
  - fb_wr_en=1.
  - db_wr_en=i_depth_wr_mask.
  - o_pass_count increments and wraps at 2^COUNT_WIDTH.
- On fail: no write strobes.
- Writes during CLEAR and pipeline writes never overlap, because DRAIN guarantees this.
- i_addr >= BUFFER_DEPTH: the fragment is dropped (treated as fail) and not counted.

Decomposition:
- depth_test_pkg holds:
  - cmp_func_e enum.
  - state_e enum {RUN, DRAIN, CLEAR}.
  - fragment struct {addr, depth, color, cmp_func, wr_mask}.
  - CMP_* constants.
- One combinational sub-module, depth_compare (depth, stored, cmp_func -> pass), reused by the bench's scoreboard model.

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> o_ready=0 for 19200+ cycles; every address written with 0xFFF/0; o_clear_done pulses once; then o_ready=1.
- Fragments addr 5: depth 0x100 LESS, then depth 0x080 LESS, consecutive cycles -> both pass, writes 0x100 then 0x080; then depth 0x090 one cycle later -> fails via W1/W2 forward, no write.
- Same addr 7, depth 0x200 LEQUAL twice back-to-back -> both pass, pass_count +2; LESS third copy -> fail.
- Fragment with i_depth_wr_mask=0, depth 0x010 -> fb_wr_en=1, db_wr_en=0; next fragment at depth 0x020 LESS passes against 0xFFF.
- i_clear asserted with i_valid=1 in RUN -> fragment not accepted; in-flight fragments complete writes before the first clear write; o_pass_count=0 at sweep start.
- i_cmp_func=NEVER on 100 random fragments -> zero write strobes; ALWAYS -> 100 writes, count=100.
